// File: rtl/mem_arbiter_pkg.sv
// Shared memory bus payloads plus arbiter state and owner encodings.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef struct packed {
    logic              mem_valid;
    logic              mem_instr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
  } mem_out_type;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic OWN_INSTR = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  // Returns 1 when the data side should win; a lone pending side always wins.
  function automatic logic pick_data(input logic pend_i, input logic pend_d,
                                     input logic last, input logic fixed);
    return pend_d && (!pend_i || fixed || (last == OWN_INSTR));
  endfunction

endpackage

// File: rtl/mem_arbiter_slot.sv
// Per-side pending-request register; a new request is captured whenever the
// slot is empty or being retired on the same edge.
module arbiter_slot
  import mem_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  mem_in_type req,
  input  logic       clear,
  output logic       pend_next_c,
  output mem_in_type slot_next_c
);

  logic       pend;
  mem_in_type slot;
  logic       capture;

  always_comb begin
    capture     = req.mem_valid && (!pend || clear);
    pend_next_c = capture || (pend && !clear);
    slot_next_c = capture ? req : slot;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend <= 1'b0;
      slot <= '0;
    end else begin
      pend <= pend_next_c;
      slot <= slot_next_c;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-to-one arbiter merging instruction and data memory buses onto one
// shared port, one outstanding transaction at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned PRIORITY = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  mem_in,
  input  mem_out_type mem_out
);

  localparam logic FIXED = (PRIORITY == 32'd1);

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  mem_in_type mem_in_d;

  logic       done, clear_i, clear_d;
  logic       pend_i_n, pend_d_n;
  mem_in_type slot_i_n, slot_d_n;
  logic       last_eff, win, grant;

  assign done    = (state_q == BUSY) && mem_out.mem_ready;
  assign clear_i = done && (owner_q == OWN_INSTR);
  assign clear_d = done && (owner_q == OWN_DATA);

  arbiter_slot u_slot_i (
    .clock       (clock),
    .reset       (reset),
    .req         (imem_in),
    .clear       (clear_i),
    .pend_next_c (pend_i_n),
    .slot_next_c (slot_i_n)
  );

  arbiter_slot u_slot_d (
    .clock       (clock),
    .reset       (reset),
    .req         (dmem_in),
    .clear       (clear_d),
    .pend_next_c (pend_d_n),
    .slot_next_c (slot_d_n)
  );

  // Grant decisions look at next-cycle slot contents so a capture or a
  // completion issues on the very next cycle without a bubble.
  always_comb begin
    state_d            = state_q;
    owner_d            = owner_q;
    last_d             = last_q;
    mem_in_d           = mem_in;
    mem_in_d.mem_valid = 1'b0;
    grant              = 1'b0;
    last_eff           = (state_q == BUSY) ? owner_q : last_q;
    win                = pick_data(pend_i_n, pend_d_n, last_eff, FIXED) ? OWN_DATA : OWN_INSTR;

    if (state_q == IDLE) begin
      grant = pend_i_n || pend_d_n;
      if (grant) state_d = BUSY;
    end else if (mem_out.mem_ready) begin
      last_d = owner_q;
      grant  = pend_i_n || pend_d_n;
      if (!grant) state_d = IDLE;
    end

    if (grant) begin
      owner_d            = win;
      mem_in_d           = (win == OWN_DATA) ? slot_d_n : slot_i_n;
      mem_in_d.mem_valid = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_INSTR;
      last_q  <= OWN_INSTR;
      mem_in  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      mem_in  <= mem_in_d;
    end
  end

  // Completion goes only to the owner; read data is broadcast.
  always_comb begin
    imem_out.mem_rdata = mem_out.mem_rdata;
    dmem_out.mem_rdata = mem_out.mem_rdata;
    imem_out.mem_ready = clear_i;
    dmem_out.mem_ready = clear_d;
  end

endmodule
